// File: rtl/axi_req_resp_cut_pkg.sv
// axi_req_resp_cut_pkg: local copy of the ariane_axi channel, req_t and resp_t types used by the cut.
// Field names and layout follow ariane_axi, so a build that has the real package can swap it in unchanged.
package axi_req_resp_cut_pkg;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 1;
   typedef logic [ID_W-1:0]     id_t;
   typedef logic [ADDR_W-1:0]   addr_t;
   typedef logic [DATA_W-1:0]   data_t;
   typedef logic [DATA_W/8-1:0] strb_t;
   typedef logic [USER_W-1:0]   user_t;
   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      user_t       user;
   } aw_chan_t;
   typedef struct packed {
      data_t data;
      strb_t strb;
      logic  last;
      user_t user;
   } w_chan_t;
   typedef struct packed {
      id_t        id;
      logic [1:0] resp;
      user_t      user;
   } b_chan_t;
   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      user_t       user;
   } ar_chan_t;
   typedef struct packed {
      id_t        id;
      data_t      data;
      logic [1:0] resp;
      logic       last;
      user_t      user;
   } r_chan_t;
   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } resp_t;
endpackage

// File: rtl/axi_chan_spill_reg.sv
// axi_chan_spill_reg: two-slot spill register for one valid/ready channel, or a plain wire when BYPASS is set.
// Ports: clk_i, rst_ni (sync, active-low); valid_i/ready_o/data_i upstream; valid_o/ready_i/data_o downstream.
module axi_chan_spill_reg #(
   parameter type T      = logic,
   parameter bit  BYPASS = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic valid_i,
   output logic ready_o,
   input  T     data_i,
   output logic valid_o,
   input  logic ready_i,
   output T     data_o
);
   if (BYPASS) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign valid_o = valid_i;
      assign data_o  = data_i;
      assign ready_o = ready_i;
   end else begin : g_spill
      logic a_full, s_full, accept, pop;
      T     a_data, s_data;
      // ready depends only on the spill slot, never on ready_i; rst_ni gating keeps it low throughout reset
      assign ready_o = rst_ni & ~s_full;
      assign valid_o = a_full;
      assign data_o  = a_data;
      assign accept  = valid_i & ready_o;
      assign pop     = a_full & ready_i;
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            a_full <= 1'b0;
            s_full <= 1'b0;
         end else begin
            a_full <= pop ? (s_full | accept) : (a_full | accept);
            s_full <= pop ? 1'b0 : (s_full | (accept & a_full));
         end
      end
      // payload is not reset: it is only observed while the matching full flag is set
      always_ff @(posedge clk_i) begin
         if (pop & s_full) a_data <= s_data;
         else if (accept & (pop | ~a_full)) a_data <= data_i;
         if (accept & a_full & ~pop) s_data <= data_i;
      end
   end
endmodule

// File: rtl/axi_req_resp_cut.sv
// axi_req_resp_cut: timing cut on an AXI req_t/resp_t pair, one spill register per channel (AW, W, B, AR, R).
// Ports: clk_i, rst_ni (sync, active-low); slv_req_i/slv_resp_o toward the upstream master,
//        mst_req_o/mst_resp_i toward the master connector. BYPASS_* turns a channel into a feedthrough.
module axi_req_resp_cut
   import axi_req_resp_cut_pkg::*;
#(
   parameter bit BYPASS_AW = 1'b0,
   parameter bit BYPASS_W  = 1'b0,
   parameter bit BYPASS_B  = 1'b0,
   parameter bit BYPASS_AR = 1'b0,
   parameter bit BYPASS_R  = 1'b0
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o,
   output req_t  mst_req_o,
   input  resp_t mst_resp_i
);
   axi_chan_spill_reg #(.T(aw_chan_t), .BYPASS(BYPASS_AW)) i_aw (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(slv_req_i.aw_valid), .ready_o(slv_resp_o.aw_ready), .data_i(slv_req_i.aw),
      .valid_o(mst_req_o.aw_valid), .ready_i(mst_resp_i.aw_ready), .data_o(mst_req_o.aw)
   );
   axi_chan_spill_reg #(.T(w_chan_t), .BYPASS(BYPASS_W)) i_w (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(slv_req_i.w_valid), .ready_o(slv_resp_o.w_ready), .data_i(slv_req_i.w),
      .valid_o(mst_req_o.w_valid), .ready_i(mst_resp_i.w_ready), .data_o(mst_req_o.w)
   );
   axi_chan_spill_reg #(.T(b_chan_t), .BYPASS(BYPASS_B)) i_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(mst_resp_i.b_valid), .ready_o(mst_req_o.b_ready), .data_i(mst_resp_i.b),
      .valid_o(slv_resp_o.b_valid), .ready_i(slv_req_i.b_ready), .data_o(slv_resp_o.b)
   );
   axi_chan_spill_reg #(.T(ar_chan_t), .BYPASS(BYPASS_AR)) i_ar (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(slv_req_i.ar_valid), .ready_o(slv_resp_o.ar_ready), .data_i(slv_req_i.ar),
      .valid_o(mst_req_o.ar_valid), .ready_i(mst_resp_i.ar_ready), .data_o(mst_req_o.ar)
   );
   axi_chan_spill_reg #(.T(r_chan_t), .BYPASS(BYPASS_R)) i_r (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(mst_resp_i.r_valid), .ready_o(mst_req_o.r_ready), .data_i(mst_resp_i.r),
      .valid_o(slv_resp_o.r_valid), .ready_i(slv_req_i.r_ready), .data_o(slv_resp_o.r)
   );
endmodule

// File: tb/tb_axi_req_resp_cut.sv
// tb_axi_req_resp_cut: directed checks of the AXI cut, default build plus a build with the R channel bypassed.
module tb_axi_req_resp_cut;
   import axi_req_resp_cut_pkg::*;
   logic  clk_i = 1'b0;
   logic  rst_ni;
   req_t  slv_req0, mst_req0, slv_req1, mst_req1;
   resp_t slv_resp0, mst_resp0, slv_resp1, mst_resp1;
   int    checks = 0;
   int    failures = 0;
   always #5 clk_i = ~clk_i;
   axi_req_resp_cut dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_req_i(slv_req0), .slv_resp_o(slv_resp0),
      .mst_req_o(mst_req0), .mst_resp_i(mst_resp0)
   );
   axi_req_resp_cut #(.BYPASS_R(1'b1)) dut_byp (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_req_i(slv_req1), .slv_resp_o(slv_resp1),
      .mst_req_o(mst_req1), .mst_resp_i(mst_resp1)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   initial begin
      slv_req0  = '0;
      mst_resp0 = '0;
      slv_req1  = '0;
      mst_resp1 = '0;
      mst_resp0.aw_ready = 1'b1;
      mst_resp0.ar_ready = 1'b1;
      mst_resp1.aw_ready = 1'b1;
      mst_resp1.w_ready  = 1'b1;
      mst_resp1.ar_ready = 1'b1;
      // reset with an AW presented the whole time
      rst_ni = 1'b0;
      slv_req0.aw_valid = 1'b1;
      slv_req0.aw.id    = 4'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valids", {mst_req0.aw_valid, mst_req0.w_valid, mst_req0.ar_valid,
                            slv_resp0.b_valid, slv_resp0.r_valid}, 64'h0);
         chk("rst_readys", {slv_resp0.aw_ready, slv_resp0.w_ready, slv_resp0.ar_ready,
                            mst_req0.b_ready, mst_req0.r_ready}, 64'h0);
      end
      rst_ni = 1'b1;
      slv_req0.aw_valid = 1'b0;
      #1;
      chk("rel_readys", {slv_resp0.aw_ready, slv_resp0.w_ready, slv_resp0.ar_ready,
                         mst_req0.b_ready, mst_req0.r_ready}, 64'h1f);
      chk("rel_valids", {mst_req0.aw_valid, mst_req0.w_valid, mst_req0.ar_valid,
                         slv_resp0.b_valid, slv_resp0.r_valid}, 64'h0);
      tick();
      chk("aw_not_fwd", mst_req0.aw_valid, 1'b0);
      // AR then an 8-beat R burst with r_ready held high
      slv_req0.ar_valid = 1'b1;
      slv_req0.ar.id    = 4'd3;
      slv_req0.ar.len   = 8'd7;
      tick();
      slv_req0.ar_valid = 1'b0;
      chk("ar_valid", mst_req0.ar_valid, 1'b1);
      chk("ar_id", mst_req0.ar.id, 64'd3);
      chk("ar_len", mst_req0.ar.len, 64'd7);
      tick();
      chk("ar_popped", mst_req0.ar_valid, 1'b0);
      slv_req0.r_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mst_resp0.r_valid = 1'b1;
         mst_resp0.r.id    = 4'd3;
         mst_resp0.r.data  = 64'(i);
         mst_resp0.r.last  = (i == 7);
         #1;
         chk("r_ready", mst_req0.r_ready, 1'b1);
         tick();
         chk("r_valid", slv_resp0.r_valid, 1'b1);
         chk("r_data", slv_resp0.r.data, 64'(i));
         chk("r_last", slv_resp0.r.last, (i == 7));
      end
      mst_resp0.r_valid = 1'b0;
      tick();
      chk("r_drained", slv_resp0.r_valid, 1'b0);
      // W backpressure and simultaneous pop+accept
      mst_resp0.w_ready = 1'b0;
      slv_req0.w_valid  = 1'b1;
      slv_req0.w.data   = 64'hA;
      tick();
      chk("w_ready_a", slv_resp0.w_ready, 1'b1);
      chk("w_out_a", mst_req0.w.data, 64'hA);
      slv_req0.w.data = 64'hB;
      tick();
      chk("w_ready_drop", slv_resp0.w_ready, 1'b0);
      chk("w_hold_a", mst_req0.w.data, 64'hA);
      slv_req0.w.data = 64'hC;
      tick();
      chk("w_stall_ready", slv_resp0.w_ready, 1'b0);
      chk("w_stall_data", mst_req0.w.data, 64'hA);
      chk("w_stall_valid", mst_req0.w_valid, 1'b1);
      mst_resp0.w_ready = 1'b1;
      tick();
      chk("w_out_b", mst_req0.w.data, 64'hB);
      chk("w_ready_back", slv_resp0.w_ready, 1'b1);
      tick();
      chk("w_out_c", mst_req0.w.data, 64'hC);
      chk("w_popacc_valid", mst_req0.w_valid, 1'b1);
      chk("w_popacc_s_empty", slv_resp0.w_ready, 1'b1);
      slv_req0.w_valid = 1'b0;
      tick();
      chk("w_drained", mst_req0.w_valid, 1'b0);
      // two B beats buffered, then reset discards them
      slv_req0.b_ready  = 1'b0;
      mst_resp0.b_valid = 1'b1;
      mst_resp0.b.id    = 4'd1;
      tick();
      mst_resp0.b.id = 4'd2;
      tick();
      mst_resp0.b_valid = 1'b0;
      chk("b_buf_valid", slv_resp0.b_valid, 1'b1);
      chk("b_buf_id", slv_resp0.b.id, 64'd1);
      chk("b_buf_full", mst_req0.b_ready, 1'b0);
      rst_ni = 1'b0;
      tick();
      chk("b_rst_valid", slv_resp0.b_valid, 1'b0);
      rst_ni = 1'b1;
      slv_req0.b_ready = 1'b1;
      tick();
      chk("b_gone", slv_resp0.b_valid, 1'b0);
      tick();
      chk("b_gone2", slv_resp0.b_valid, 1'b0);
      // bypassed R is combinational; AR in the same build still registered
      slv_req1.r_ready  = 1'b1;
      mst_resp1.r_valid = 1'b1;
      mst_resp1.r.data  = 64'h55;
      mst_resp1.r.last  = 1'b1;
      #1;
      chk("byp_r_valid", slv_resp1.r_valid, 1'b1);
      chk("byp_r_data", slv_resp1.r.data, 64'h55);
      chk("byp_r_last", slv_resp1.r.last, 1'b1);
      chk("byp_r_ready1", mst_req1.r_ready, 1'b1);
      slv_req1.r_ready = 1'b0;
      #1;
      chk("byp_r_ready0", mst_req1.r_ready, 1'b0);
      mst_resp1.r_valid = 1'b0;
      #1;
      chk("byp_r_valid0", slv_resp1.r_valid, 1'b0);
      slv_req1.ar_valid = 1'b1;
      slv_req1.ar.id    = 4'd9;
      #1;
      chk("byp_ar_lat0", mst_req1.ar_valid, 1'b0);
      tick();
      slv_req1.ar_valid = 1'b0;
      chk("byp_ar_lat1", mst_req1.ar_valid, 1'b1);
      chk("byp_ar_id", mst_req1.ar.id, 64'd9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
